// File: rtl/pfb_deadlock_watchdog.sv
// Deadlock watchdog for the PFB dataflow kernel: counts consecutive stuck cycles,
// latches a snapshot of the blockers on timeout and classifies the event as internal or external.
module pfb_deadlock_watchdog #(
    parameter int N_AXIS    = 12,
    parameter int N_INST    = 3,
    parameter int TIMEOUT_W = 16,
    localparam int IW = (N_INST > 1) ? $clog2(N_INST) : 1,
    localparam int AW = (N_AXIS > 1) ? $clog2(N_AXIS) : 1
) (
    input  logic                 kernel_monitor_clock,
    input  logic                 kernel_monitor_reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic [N_AXIS-1:0]    axis_block_sigs,
    input  logic [N_INST-1:0]    inst_idle_sigs,
    input  logic [N_INST-1:0]    inst_block_sigs,
    output logic                 kernel_block,
    output logic                 deadlock_external,
    output logic [IW-1:0]        first_inst_idx,
    output logic [AW-1:0]        first_axis_idx,
    output logic [N_INST-1:0]    inst_block_snap,
    output logic [N_AXIS-1:0]    axis_block_snap,
    output logic [TIMEOUT_W-1:0] stall_count,
    output logic [TIMEOUT_W-1:0] max_stall,
    output logic [1:0]           mon_state
);

    typedef enum logic [1:0] {
        MON_IDLE     = 2'd0,
        MON_WATCH    = 2'd1,
        MON_DEADLOCK = 2'd2
    } mon_state_e;

    mon_state_e            state_q, state_d;
    logic                  kb_q, kb_d;
    logic                  ext_q, ext_d;
    logic [IW-1:0]         fi_q, fi_d;
    logic [AW-1:0]         fa_q, fa_d;
    logic [N_INST-1:0]     isnap_q, isnap_d;
    logic [N_AXIS-1:0]     asnap_q, asnap_d;
    logic [TIMEOUT_W-1:0]  stall_q, stall_d;
    logic [TIMEOUT_W-1:0]  max_q, max_d;

    logic                  stuck;
    logic [TIMEOUT_W:0]    stall_p1;
    logic [TIMEOUT_W-1:0]  stall_sat;
    logic [TIMEOUT_W-1:0]  cnt_next;
    logic [TIMEOUT_W-1:0]  max_upd;
    logic [TIMEOUT_W-1:0]  thr;
    logic                  trip_hit;

    function automatic logic [IW-1:0] low_inst(input logic [N_INST-1:0] v);
        low_inst = '0;
        for (int i = N_INST - 1; i >= 0; i--) begin
            if (v[i]) low_inst = IW'(i);
        end
    endfunction

    function automatic logic [AW-1:0] low_axis(input logic [N_AXIS-1:0] v);
        low_axis = '0;
        for (int i = N_AXIS - 1; i >= 0; i--) begin
            if (v[i]) low_axis = AW'(i);
        end
    endfunction

    // Stuck: someone is blocked and nobody is running unblocked.
    assign stuck     = (|inst_block_sigs) & (&(inst_idle_sigs | inst_block_sigs));
    assign stall_p1  = {1'b0, stall_q} + {{TIMEOUT_W{1'b0}}, 1'b1};
    assign stall_sat = stall_p1[TIMEOUT_W] ? {TIMEOUT_W{1'b1}} : stall_p1[TIMEOUT_W-1:0];
    assign cnt_next  = stuck ? stall_sat : '0;
    assign max_upd   = (cnt_next > max_q) ? cnt_next : max_q;
    assign thr       = (timeout_cycles == '0) ? TIMEOUT_W'(1) : timeout_cycles;
    assign trip_hit  = stuck && (stall_p1 >= {1'b0, thr});

    always_comb begin
        state_d = state_q;
        kb_d    = kb_q;
        ext_d   = ext_q;
        fi_d    = fi_q;
        fa_d    = fa_q;
        isnap_d = isnap_q;
        asnap_d = asnap_q;
        stall_d = stall_q;
        max_d   = max_q;
        case (state_q)
            MON_IDLE: begin
                stall_d = '0;
                if (clear) max_d = '0;
                if (enable) state_d = MON_WATCH;
            end
            MON_WATCH: begin
                if (!enable) begin
                    state_d = MON_IDLE;
                    stall_d = '0;
                    if (clear) max_d = '0;
                end else if (clear) begin
                    // Clear beats a coincident trip.
                    stall_d = '0;
                    max_d   = '0;
                end else begin
                    stall_d = cnt_next;
                    max_d   = max_upd;
                    if (trip_hit) begin
                        state_d = MON_DEADLOCK;
                        kb_d    = 1'b1;
                        ext_d   = |axis_block_sigs;
                        fi_d    = low_inst(inst_block_sigs);
                        fa_d    = low_axis(axis_block_sigs);
                        isnap_d = inst_block_sigs;
                        asnap_d = axis_block_sigs;
                    end
                end
            end
            MON_DEADLOCK: begin
                if (clear) begin
                    state_d = MON_WATCH;
                    kb_d    = 1'b0;
                    ext_d   = 1'b0;
                    fi_d    = '0;
                    fa_d    = '0;
                    isnap_d = '0;
                    asnap_d = '0;
                    stall_d = '0;
                end else begin
                    stall_d = cnt_next;
                    max_d   = max_upd;
                end
            end
            default: state_d = MON_IDLE;
        endcase
    end

    always_ff @(posedge kernel_monitor_clock) begin
        if (!kernel_monitor_reset) begin
            state_q <= MON_IDLE;
            kb_q    <= 1'b0;
            ext_q   <= 1'b0;
            fi_q    <= '0;
            fa_q    <= '0;
            isnap_q <= '0;
            asnap_q <= '0;
            stall_q <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            kb_q    <= kb_d;
            ext_q   <= ext_d;
            fi_q    <= fi_d;
            fa_q    <= fa_d;
            isnap_q <= isnap_d;
            asnap_q <= asnap_d;
            stall_q <= stall_d;
            max_q   <= max_d;
        end
    end

    assign kernel_block      = kb_q;
    assign deadlock_external = ext_q;
    assign first_inst_idx    = fi_q;
    assign first_axis_idx    = fa_q;
    assign inst_block_snap   = isnap_q;
    assign axis_block_snap   = asnap_q;
    assign stall_count       = stall_q;
    assign max_stall         = max_q;
    assign mon_state         = state_q;

endmodule

// File: tb/tb_pfb_deadlock_watchdog.sv
// Bench for pfb_deadlock_watchdog: directed scenarios plus random traffic, every cycle
// compared against a mode/counter reference model.
module tb_pfb_deadlock_watchdog;

    localparam int NA  = 12;
    localparam int NI  = 3;
    localparam int W   = 16;
    localparam int SAT = (1 << W) - 1;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          clear;
    logic [W-1:0]  timeout_cycles;
    logic [NA-1:0] axis_block_sigs;
    logic [NI-1:0] inst_idle_sigs;
    logic [NI-1:0] inst_block_sigs;
    logic          kernel_block;
    logic          deadlock_external;
    logic [1:0]    first_inst_idx;
    logic [3:0]    first_axis_idx;
    logic [NI-1:0] inst_block_snap;
    logic [NA-1:0] axis_block_snap;
    logic [W-1:0]  stall_count;
    logic [W-1:0]  max_stall;
    logic [1:0]    mon_state;

    pfb_deadlock_watchdog #(.N_AXIS(NA), .N_INST(NI), .TIMEOUT_W(W)) dut (
        .kernel_monitor_clock(clk),
        .kernel_monitor_reset(rst_n),
        .enable(enable),
        .clear(clear),
        .timeout_cycles(timeout_cycles),
        .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs(inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs),
        .kernel_block(kernel_block),
        .deadlock_external(deadlock_external),
        .first_inst_idx(first_inst_idx),
        .first_axis_idx(first_axis_idx),
        .inst_block_snap(inst_block_snap),
        .axis_block_snap(axis_block_snap),
        .stall_count(stall_count),
        .max_stall(max_stall),
        .mon_state(mon_state)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // reference model: mode 0=idle, 1=watching, 2=deadlocked
    int            m_mode, m_stall, m_max, m_fi, m_fa;
    bit            m_kb, m_ext;
    logic [NI-1:0] m_isnap;
    logic [NA-1:0] m_asnap;

    function automatic int lowest(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_edge();
        bit stuck;
        int nxt, thr;
        if (!rst_n) begin
            m_mode = 0; m_stall = 0; m_max = 0; m_fi = 0; m_fa = 0;
            m_kb = 0; m_ext = 0; m_isnap = '0; m_asnap = '0;
            return;
        end
        stuck = (inst_block_sigs != 0) && ((inst_idle_sigs | inst_block_sigs) == {NI{1'b1}});
        nxt   = stuck ? ((m_stall + 1 > SAT) ? SAT : m_stall + 1) : 0;
        thr   = (timeout_cycles == 0) ? 1 : int'(timeout_cycles);
        if (m_mode == 0) begin
            m_stall = 0;
            if (clear) m_max = 0;
            if (enable) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!enable) begin
                m_mode = 0; m_stall = 0;
                if (clear) m_max = 0;
            end else if (clear) begin
                m_stall = 0; m_max = 0;
            end else begin
                if (stuck && (m_stall + 1 >= thr)) begin
                    m_mode = 2; m_kb = 1;
                    m_ext = (axis_block_sigs != 0);
                    m_fi = lowest(32'(inst_block_sigs));
                    m_fa = lowest(32'(axis_block_sigs));
                    m_isnap = inst_block_sigs; m_asnap = axis_block_sigs;
                end
                m_stall = nxt;
                if (nxt > m_max) m_max = nxt;
            end
        end else begin
            if (clear) begin
                m_mode = 1; m_kb = 0; m_ext = 0; m_fi = 0; m_fa = 0;
                m_isnap = '0; m_asnap = '0; m_stall = 0;
            end else begin
                m_stall = nxt;
                if (nxt > m_max) m_max = nxt;
            end
        end
    endtask

    task automatic check_all();
        check("kernel_block", 32'(kernel_block), 32'(m_kb));
        check("deadlock_external", 32'(deadlock_external), 32'(m_ext));
        check("first_inst_idx", 32'(first_inst_idx), 32'(m_fi));
        check("first_axis_idx", 32'(first_axis_idx), 32'(m_fa));
        check("inst_block_snap", 32'(inst_block_snap), 32'(m_isnap));
        check("axis_block_snap", 32'(axis_block_snap), 32'(m_asnap));
        check("stall_count", 32'(stall_count), 32'(m_stall));
        check("max_stall", 32'(max_stall), 32'(m_max));
        check("mon_state", 32'(mon_state), 32'(m_mode));
    endtask

    // driver tasks
    task automatic cycle(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    task automatic drive(input logic [NI-1:0] ib, input logic [NI-1:0] ii, input logic [NA-1:0] ab);
        inst_block_sigs = ib;
        inst_idle_sigs  = ii;
        axis_block_sigs = ab;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; timeout_cycles = '0;
        drive('0, '0, '0);
        m_mode = 0; m_stall = 0; m_max = 0; m_fi = 0; m_fa = 0;
        m_kb = 0; m_ext = 0; m_isnap = '0; m_asnap = '0;
        cycle(2);

        // 1: reset, enabled, nothing blocked
        rst_n = 1'b1; enable = 1'b1;
        cycle(10);
        check("t1_state_watch", 32'(mon_state), 32'd1);
        check("t1_kb", 32'(kernel_block), 32'd0);
        check("t1_max", 32'(max_stall), 32'd0);

        // 2: internal deadlock, timeout 4
        timeout_cycles = 16'd4;
        drive(3'b010, 3'b101, '0);
        cycle(3);
        check("t2_stall3", 32'(stall_count), 32'd3);
        check("t2_no_trip_yet", 32'(kernel_block), 32'd0);
        cycle(1);
        check("t2_trip", 32'(kernel_block), 32'd1);
        check("t2_fi", 32'(first_inst_idx), 32'd1);
        check("t2_snap", 32'(inst_block_snap), 32'b010);
        check("t2_ext", 32'(deadlock_external), 32'd0);
        clear = 1'b1; drive('0, 3'b111, '0);
        cycle(1);
        clear = 1'b0;

        // 3: external deadlock with AXIS port 8 blocked
        drive(3'b110, 3'b001, 12'h100);
        cycle(4);
        check("t3_trip", 32'(kernel_block), 32'd1);
        check("t3_fa", 32'(first_axis_idx), 32'd8);
        check("t3_fi", 32'(first_inst_idx), 32'd1);
        check("t3_ext", 32'(deadlock_external), 32'd1);
        clear = 1'b1; drive('0, 3'b111, '0);
        cycle(2);
        clear = 1'b0;
        check("t3_max_cleared", 32'(max_stall), 32'd0);

        // 4: stall broken by one running cycle
        drive(3'b010, 3'b101, '0);
        cycle(3);
        drive(3'b010, 3'b100, '0);
        cycle(1);
        check("t4_stall_reset", 32'(stall_count), 32'd0);
        check("t4_max3", 32'(max_stall), 32'd3);
        drive(3'b010, 3'b101, '0);
        cycle(3);
        check("t4_no_trip", 32'(kernel_block), 32'd0);
        cycle(1);
        check("t4_trip", 32'(kernel_block), 32'd1);

        // 5: clear while still stuck, timeout 2
        timeout_cycles = 16'd2;
        clear = 1'b1;
        cycle(1);
        clear = 1'b0;
        check("t5_dropped", 32'(kernel_block), 32'd0);
        cycle(1);
        check("t5_not_yet", 32'(kernel_block), 32'd0);
        cycle(1);
        check("t5_retrip", 32'(kernel_block), 32'd1);
        check("t5_max_kept", 32'(max_stall), 32'd4);

        // 6: timeout 0 behaves as 1; reset mid-deadlock
        clear = 1'b1; drive('0, 3'b111, '0);
        cycle(1);
        clear = 1'b0; timeout_cycles = '0;
        drive(3'b001, 3'b110, 12'h00c);
        cycle(1);
        check("t6_trip1", 32'(kernel_block), 32'd1);
        check("t6_fa", 32'(first_axis_idx), 32'd2);
        rst_n = 1'b0;
        cycle(1);
        check("t6_rst_kb", 32'(kernel_block), 32'd0);
        check("t6_rst_max", 32'(max_stall), 32'd0);
        check("t6_rst_state", 32'(mon_state), 32'd0);
        rst_n = 1'b1;

        // collision: clear at the would-be trip cycle
        enable = 1'b1; timeout_cycles = 16'd2;
        drive(3'b100, 3'b011, '0);
        cycle(2);
        clear = 1'b1;
        cycle(1);
        clear = 1'b0;
        check("clr_beats_trip", 32'(kernel_block), 32'd0);
        check("clr_stall0", 32'(stall_count), 32'd0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [NI-1:0] ib;
            rst_n  = ($urandom_range(0, 199) != 0);
            enable = ($urandom_range(0, 15) != 0);
            clear  = ($urandom_range(0, 19) == 0);
            timeout_cycles = 16'($urandom_range(0, 6));
            ib = NI'($urandom_range(0, 7));
            drive(ib,
                  ($urandom_range(0, 3) == 0) ? NI'($urandom_range(0, 7)) : ~ib,
                  ($urandom_range(0, 2) == 0) ? NA'($urandom_range(0, 4095)) : '0);
            cycle(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pfb_deadlock_watchdog.md
Name: pfb_deadlock_watchdog

Overview:
- Synthesizable, parametrised deadlock watchdog for the PFB dataflow kernel (read_inputs -> compute_pfb -> write_outputs and wider variants).
- Consumes per-port AXIS block flags and per-process idle/block flags.
- Flags a deadlock only after a programmable number of consecutive stuck cycles, then latches a snapshot of the blockers.
- Classifies the event as internal (FIFO cycle) or external (AXIS starvation/backpressure), so the block is usable on hardware as well as in simulation.

Parameters:
- N_AXIS, 12, number of AXIS port block flags.
- N_INST, 3, number of dataflow process instances monitored.
- TIMEOUT_W, 16, width of the timeout threshold and stall counters.

Ports:
- kernel_monitor_clock  in  1  sole clock.
- kernel_monitor_reset  in  1  synchronous, active-low reset.
- enable  in  1  monitoring enable.
- clear  in  1  single-cycle clear of sticky status.
- timeout_cycles  in  TIMEOUT_W  consecutive stuck cycles required to declare deadlock; 0 is treated as 1.
- axis_block_sigs  in  N_AXIS  1 = AXIS port blocked.
- inst_idle_sigs  in  N_INST  1 = instance idle.
- inst_block_sigs  in  N_INST  1 = instance blocked on a FIFO or ap_continue.
- kernel_block  out  1  sticky deadlock flag.
- deadlock_external  out  1  valid with kernel_block; 1 = at least one AXIS flag was set at detection.
- first_inst_idx  out  max(1,$clog2(N_INST))  lowest-index blocked instance at detection.
- first_axis_idx  out  max(1,$clog2(N_AXIS))  lowest-index blocked AXIS port at detection; 0 if none.
- inst_block_snap  out  N_INST  inst_block_sigs captured at detection.
- axis_block_snap  out  N_AXIS  axis_block_sigs captured at detection.
- stall_count  out  TIMEOUT_W  current consecutive stuck count.
- max_stall  out  TIMEOUT_W  saturating high-water mark of stall_count.

Behaviour:
One clock; reset is synchronous and active-low.

Reset (kernel_monitor_reset=0 at a clock edge):
- FSM to MON_IDLE.
- All outputs and all registers to 0.

Stuck condition (combinational):
- stuck = (|inst_block_sigs) & (&(inst_idle_sigs | inst_block_sigs)).
- Meaning: at least one instance is blocked and no instance is running unblocked.
- All-idle is never stuck.

FSM:
- MON_IDLE:
  - stall_count held at 0.
  - enable=1 -> MON_WATCH on the next edge.
- MON_WATCH:
  - Each cycle, stuck=1 increments stall_count (saturating at all-ones); stuck=0 loads 0.
  - max_stall updates to stall_count+1 whenever that value exceeds it; it does not wrap.
  - Trip condition: stuck=1 and stall_count+1 >= max(timeout_cycles,1).
  - On trip, at that edge: go to MON_DEADLOCK, set kernel_block=1, capture both snapshots, both first indices, and deadlock_external = |axis_block_sigs.
  - Latency: with timeout_cycles=T, kernel_block rises at the edge ending the T-th consecutive stuck cycle, so it is visible on cycle T+1.
  - enable=0 -> MON_IDLE; stall_count goes to 0; max_stall is kept.
- MON_DEADLOCK:
  - kernel_block, snapshots and indices hold regardless of inputs or enable.
  - stall_count continues counting/saturating while stuck and loads 0 when not stuck.
  - clear=1 -> MON_WATCH; kernel_block, snapshots, indices, deadlock_external and stall_count go to 0; max_stall is kept.

Clear:
- clear=1 in MON_WATCH or MON_IDLE additionally zeroes max_stall.
- clear and trip in the same cycle: clear wins; no deadlock latched; stall_count goes to 0.

Indices and snapshots:
- Index encoding is priority-lowest-set-bit.
- first_inst_idx is always valid at trip, since stuck guarantees some block bit is set.
- timeout_cycles changes take effect on the next comparison; there is no internal copy.
- Reset mid-deadlock clears everything, including max_stall.

Test Plan:
1. Reset with all inputs X-free and enable=1 for 10 cycles, no block bits -> kernel_block=0, stall_count=0, max_stall=0, FSM in MON_WATCH.
2. timeout_cycles=4; inst_block=3'b010, inst_idle=3'b101 held -> stall_count 1,2,3; kernel_block rises after the 4th stuck cycle; first_inst_idx=1; inst_block_snap=3'b010; deadlock_external=0.
3. Same as 2 but axis_block_sigs[8]=1 and inst_block=3'b110 -> first_axis_idx=8, first_inst_idx=1, deadlock_external=1.
4. Stuck for 3 cycles, one unblocked cycle (inst_idle[0]=0, inst_block[0]=0), stuck again, timeout=4 -> stall_count returns to 0; no trip until 4 new consecutive cycles; max_stall=3 before trip.
5. In MON_DEADLOCK, pulse clear while still stuck, timeout=2 -> kernel_block drops the cycle after clear, re-trips 2 cycles later, max_stall retained.
6. timeout_cycles=0 with stuck asserted one cycle -> trip after 1 cycle; separately, drive kernel_monitor_reset=0 while in MON_DEADLOCK -> every output 0 on the next edge.
